modulo_transpor_seq: RTL

//  Sequential, parametrised N x N matrix transposer for the arithmetic coprocessor datapath.

---
 rtl/modulo_transpor_seq_if.sv | 26 ++
 rtl/modulo_transpor_seq.sv | 92 +++++++++
 2 files changed

// File: rtl/modulo_transpor_seq_if.sv
// Packed-matrix transposer bus: start/mode/size/matrix_in from the requester, result and status back.
// Pure wiring, no latency; requester must hold off start while busy is high.
// master = requester side, slave = transposer side.
interface modulo_transpor_seq_if #(
    parameter int N   = 5,
    parameter int W   = 9,
    parameter int SZW = $clog2(N + 1)
);
    logic                 start;
    logic                 mode;
    logic [SZW-1:0]       size;
    logic [N*N*W-1:0]     matrix_in;
    logic [N*N*W-1:0]     matrix_out;
    logic                 busy;
    logic                 done;

    modport master (
        output start, mode, size, matrix_in,
        input  matrix_out, busy, done
    );

    modport slave (
        input  start, mode, size, matrix_in,
        output matrix_out, busy, done
    );
endinterface

// File: rtl/modulo_transpor_seq.sv
// Sequential N x N transposer: captures on start, then swaps one upper/lower-triangle pair per clock.
// Latency: done pulses s*(s-1)/2 + 1 cycles after the accept edge (1 cycle for capture-only ops).
// Backpressure: start is only accepted while busy is low; starts during a run are dropped.
module modulo_transpor_seq #(
    parameter int N = 5,
    parameter int W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    modulo_transpor_seq_if.slave bus
);
    localparam int SZW = $clog2(N + 1);
    localparam int CW  = $clog2(N);
    localparam int MW  = N * N * W;

    typedef enum logic {IDLE, SWAP} state_t;

    state_t         state_q, state_d;
    logic [MW-1:0]  mat_q, mat_d;
    logic [SZW-1:0] s_q, s_d, s_eff;
    logic [CW-1:0]  i_q, i_d, j_q, j_d;
    logic           done_q, done_d;
    logic           last_pair;
    logic           row_end;

    assign s_eff     = (int'(bus.size) > N) ? SZW'(N) : bus.size;
    assign row_end   = (int'(j_q) == int'(s_q) - 1);
    assign last_pair = row_end && (int'(i_q) == int'(s_q) - 2);

    always_comb begin
        state_d = state_q;
        mat_d   = mat_q;
        s_d     = s_q;
        i_d     = i_q;
        j_d     = j_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mat_d = bus.matrix_in;
                    s_d   = s_eff;
                    i_d   = '0;
                    j_d   = CW'(1);
                    if (!bus.mode && (s_eff >= SZW'(2))) begin
                        state_d = SWAP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SWAP: begin
                // i < j always holds, so the diagonal is never touched
                mat_d[(int'(i_q) * N + int'(j_q)) * W +: W] = mat_q[(int'(j_q) * N + int'(i_q)) * W +: W];
                mat_d[(int'(j_q) * N + int'(i_q)) * W +: W] = mat_q[(int'(i_q) * N + int'(j_q)) * W +: W];
                if (last_pair) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    i_d     = '0;
                    j_d     = CW'(1);
                end else if (row_end) begin
                    i_d = i_q + CW'(1);
                    j_d = i_q + CW'(2);
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mat_q   <= '0;
            s_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            s_q     <= s_d;
            i_q     <= i_d;
            j_q     <= j_d;
            done_q  <= done_d;
        end
    end

    assign bus.matrix_out = mat_q;
    assign bus.busy       = (state_q == SWAP);
    assign bus.done       = done_q;
endmodule
